// File: rtl/stepmotor_drv_sequencer_pkg.sv
// Shared encodings for the stepper driver sequencer: FSM states, pin owner
// codes and a small elaboration-time helper.
package stepmotor_drv_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAKE      = 3'd1,
        ST_DIR_WAIT  = 3'd2,
        ST_DIR_SETUP = 3'd3,
        ST_STEP_HIGH = 3'd4,
        ST_STEP_LOW  = 3'd5,
        ST_HOLD      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_TRK  = 2'd1,
        OWN_JOG  = 2'd2
    } owner_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stepmotor_drv_sequencer_step_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// Loading N-1 on a state entry makes done rise in that state's N-th cycle.
module stepmotor_drv_sequencer_step_timer
    import stepmotor_drv_sequencer_pkg::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    // Count down to zero and park there until the next load.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/stepmotor_drv_sequencer.sv
// Stepper driver pin sequencer: arbitrates tracking and jog requesters (jog
// wins), inserts enable wake-up, DIR setup/hold, STEP width and minimum period
// timing, and keeps a signed step position. Durations must all be >= 1,
// MIN_PERIOD must exceed PULSE_HIGH and EN_HOLD must be >= DIR_HOLD.
module stepmotor_drv_sequencer
    import stepmotor_drv_sequencer_pkg::*;
#(
    parameter int PERIOD_W   = 17,
    parameter int POS_W      = 32,
    parameter int PULSE_HIGH = 50,
    parameter int MIN_PERIOD = 200,
    parameter int DIR_SETUP  = 250,
    parameter int DIR_HOLD   = 250,
    parameter int EN_WAKE    = 50000,
    parameter int EN_HOLD    = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trk_en,
    input  logic [PERIOD_W-1:0] trk_period,
    input  logic                trk_dir,
    input  logic                jog_en,
    input  logic [PERIOD_W-1:0] jog_period,
    input  logic                jog_dir,
    input  logic                estop,
    input  logic                pos_clr,
    output logic                drv_step,
    output logic                drv_dir,
    output logic                drv_enable,
    output logic [1:0]          owner,
    output logic                busy,
    output logic                step_strobe,
    output logic [POS_W-1:0]    position
);

    localparam int TIMER_MAX = max_int(max_int(2 ** PERIOD_W, EN_WAKE),
                                       max_int(max_int(EN_HOLD, DIR_SETUP),
                                               max_int(DIR_HOLD, MIN_PERIOD)));
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    state_t               state, next_state;
    owner_t               owner_q, sel_owner;
    logic                 trk_valid, jog_valid, sel_valid, sel_dir;
    logic                 pend_dir, step_go;
    logic                 tmr_load, tmr_done;
    logic [TIMER_W-1:0]   tmr_value, period_q, own_period, eff_period;

    // Requester selection: jog has priority, a zero period means no request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sel_owner = OWN_NONE;
        sel_dir   = 1'b0;
        trk_valid = trk_en && (trk_period != '0);
        jog_valid = jog_en && (jog_period != '0);
        if (jog_valid) begin
            sel_owner = OWN_JOG;
            sel_dir   = jog_dir;
        end else if (trk_valid) begin
            sel_owner = OWN_TRK;
            sel_dir   = trk_dir;
        end
        sel_valid  = jog_valid || trk_valid;
        own_period = (owner_q == OWN_JOG) ? TIMER_W'(jog_period) : TIMER_W'(trk_period);
        eff_period = (own_period < TIMER_W'(MIN_PERIOD)) ? TIMER_W'(MIN_PERIOD) : own_period;
    end

    stepmotor_drv_sequencer_step_timer #(.W(TIMER_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and timer reload; arbitration only in IDLE, HOLD and the last STEP_LOW cycle.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        if (estop) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (sel_valid) begin
                    next_state = ST_WAKE;
                    tmr_load   = 1'b1;
                    tmr_value  = TIMER_W'(EN_WAKE - 1);
                end
                ST_WAKE, ST_DIR_WAIT: if (tmr_done) begin
                    next_state = ST_DIR_SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = TIMER_W'(DIR_SETUP - 1);
                end
                ST_DIR_SETUP: if (tmr_done) begin
                    next_state = ST_STEP_HIGH;
                    tmr_load   = 1'b1;
                    tmr_value  = TIMER_W'(PULSE_HIGH - 1);
                end
                ST_STEP_HIGH: if (tmr_done) begin
                    next_state = ST_STEP_LOW;
                    tmr_load   = 1'b1;
                    tmr_value  = period_q - TIMER_W'(PULSE_HIGH + 1);
                end
                ST_STEP_LOW: if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (sel_valid && (sel_owner == owner_q) && (sel_dir == drv_dir)) begin
                        next_state = ST_STEP_HIGH;
                        tmr_value  = TIMER_W'(PULSE_HIGH - 1);
                    end else if (sel_valid) begin
                        next_state = ST_DIR_WAIT;
                        tmr_value  = TIMER_W'(DIR_HOLD - 1);
                    end else begin
                        next_state = ST_HOLD;
                        tmr_value  = TIMER_W'(EN_HOLD - 1);
                    end
                end
                ST_HOLD: if (sel_valid) begin
                    next_state = ST_DIR_SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = TIMER_W'(DIR_SETUP - 1);
                end else if (tmr_done) begin
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Driver pin decode from the current state.
    always_comb begin
        drv_step   = (state == ST_STEP_HIGH);
        drv_enable = (state != ST_IDLE);
        busy       = (state != ST_IDLE);
    end

    assign step_go = (next_state == ST_STEP_HIGH) && (state != ST_STEP_HIGH);
    assign owner   = owner_q;

    // Owner, DIR and period capture at the transitions that own them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            drv_dir  <= 1'b0;
            pend_dir <= 1'b0;
            period_q <= '0;
        end else begin
            if ((next_state == ST_IDLE) || (next_state == ST_HOLD)) begin
                owner_q <= OWN_NONE;
            end else if (((state == ST_IDLE) && (next_state == ST_WAKE)) ||
                         ((state == ST_HOLD) && (next_state == ST_DIR_SETUP))) begin
                owner_q <= sel_owner;
                drv_dir <= sel_dir;
            end else if ((state == ST_STEP_LOW) && (next_state == ST_DIR_WAIT)) begin
                owner_q  <= sel_owner;
                pend_dir <= sel_dir;
            end else if ((state == ST_DIR_WAIT) && (next_state == ST_DIR_SETUP)) begin
                drv_dir <= pend_dir;
            end
            if (step_go) begin
                period_q <= eff_period;
            end
        end
    end

    // Step strobe and position: count on STEP_HIGH entry, clear-then-count when coincident.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_strobe <= 1'b0;
            position    <= '0;
        end else begin
            step_strobe <= step_go;
            if (step_go) begin
                position <= (pos_clr ? '0 : position) + (drv_dir ? POS_W'(1) : {POS_W{1'b1}});
            end else if (pos_clr) begin
                position <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stepmotor_drv_sequencer.sv
// Self-checking bench for stepmotor_drv_sequencer with shortened timing.
// Step rise times, enable release and position are predicted arithmetically
// from request start, effective period and drop time.
module tb_stepmotor_drv_sequencer;

    localparam int PERIOD_W   = 17;
    localparam int POS_W      = 32;
    localparam int PULSE_HIGH = 2;
    localparam int MIN_PERIOD = 8;
    localparam int DIR_SETUP  = 3;
    localparam int DIR_HOLD   = 3;
    localparam int EN_WAKE    = 5;
    localparam int EN_HOLD    = 10;
    localparam int FIRST_OFS  = 1 + EN_WAKE + DIR_SETUP;

    typedef struct {
        int period;
        bit dir;
        bit use_jog;
        bit decoy_en;
        int nsteps;
        int exp_spacing;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                trk_en, trk_dir, jog_en, jog_dir, estop, pos_clr;
    logic [PERIOD_W-1:0] trk_period, jog_period;
    logic                drv_step, drv_dir, drv_enable, busy, step_strobe;
    logic [1:0]          owner;
    logic [POS_W-1:0]    position;

    int                  cyc = 0;
    int                  n_tests = 0;
    int                  n_fail = 0;
    int                  rises[$];
    logic [POS_W-1:0]    pos_model;
    vec_t                tbl[5];

    stepmotor_drv_sequencer #(
        .PERIOD_W(PERIOD_W), .POS_W(POS_W), .PULSE_HIGH(PULSE_HIGH),
        .MIN_PERIOD(MIN_PERIOD), .DIR_SETUP(DIR_SETUP), .DIR_HOLD(DIR_HOLD),
        .EN_WAKE(EN_WAKE), .EN_HOLD(EN_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .trk_en(trk_en), .trk_period(trk_period), .trk_dir(trk_dir),
        .jog_en(jog_en), .jog_period(jog_period), .jog_dir(jog_dir),
        .estop(estop), .pos_clr(pos_clr),
        .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable(drv_enable),
        .owner(owner), .busy(busy), .step_strobe(step_strobe), .position(position)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) if (step_strobe) rises.push_back(cyc);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected summary before 1 ms");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Move to cycle c, just after its rising edge, to change inputs.
    task automatic drive_at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Move to the falling edge of cycle c to sample outputs.
    task automatic at_cycle(input int c);
        drive_at(c);
        wait (clk === 1'b0);
    endtask

    task automatic idle_inputs();
        trk_en = 1'b0; trk_period = '0; trk_dir = 1'b0;
        jog_en = 1'b0; jog_period = '0; jog_dir = 1'b0;
    endtask

    task automatic run_track(input string tag, input int period, input bit dir, input bit use_jog,
                             input bit decoy_en, input int nsteps, input int sp);
        int t0, first, last, d, idle_t;
        logic [POS_W-1:0] exp_pos;
        t0     = cyc + 2;
        first  = t0 + FIRST_OFS;
        last   = first + (nsteps - 1) * sp;
        d      = last + 3;
        idle_t = last + sp + EN_HOLD;
        exp_pos = dir ? pos_model + POS_W'(nsteps) : pos_model - POS_W'(nsteps);
        drive_at(t0);
        rises.delete();
        if (use_jog) begin
            jog_en = 1'b1; jog_period = PERIOD_W'(period); jog_dir = dir;
            trk_en = decoy_en; trk_period = decoy_en ? '0 : PERIOD_W'(17); trk_dir = ~dir;
        end else begin
            trk_en = 1'b1; trk_period = PERIOD_W'(period); trk_dir = dir;
            jog_en = decoy_en; jog_period = decoy_en ? '0 : PERIOD_W'(17); jog_dir = ~dir;
        end
        at_cycle(t0);
        check({tag, "_en_pre"}, drv_enable, 1'b0);
        at_cycle(t0 + 1);
        check({tag, "_en_wake"}, drv_enable, 1'b1);
        check({tag, "_owner"}, owner, use_jog ? 2'd2 : 2'd1);
        at_cycle(first - 1);
        check({tag, "_step_pre"}, drv_step, 1'b0);
        check({tag, "_dir"}, drv_dir, dir);
        at_cycle(first);
        check({tag, "_step_rise"}, drv_step, 1'b1);
        check({tag, "_strobe"}, step_strobe, 1'b1);
        at_cycle(first + PULSE_HIGH - 1);
        check({tag, "_step_hold"}, drv_step, 1'b1);
        check({tag, "_strobe_1cyc"}, step_strobe, 1'b0);
        at_cycle(first + PULSE_HIGH);
        check({tag, "_step_fall"}, drv_step, 1'b0);
        drive_at(d);
        idle_inputs();
        at_cycle(idle_t - 1);
        check({tag, "_en_hold"}, drv_enable, 1'b1);
        at_cycle(idle_t);
        check({tag, "_en_release"}, drv_enable, 1'b0);
        check({tag, "_busy_idle"}, busy, 1'b0);
        check({tag, "_nsteps"}, rises.size(), nsteps);
        for (int k = 0; k < nsteps && k < rises.size(); k++) begin
            check($sformatf("%s_rise%0d", tag, k), rises[k], first + k * sp);
        end
        check({tag, "_position"}, position, exp_pos);
        pos_model = exp_pos;
    endtask

    initial begin
        int t0, first, period, sp;
        bit dir;

        rst = 1'b1; estop = 1'b0; pos_clr = 1'b0;
        idle_inputs();
        pos_model = '0;
        tbl[0] = '{period: 20, dir: 1'b1, use_jog: 1'b0, decoy_en: 1'b0, nsteps: 3, exp_spacing: 20};
        tbl[1] = '{period: 4,  dir: 1'b1, use_jog: 1'b0, decoy_en: 1'b1, nsteps: 3, exp_spacing: 8};
        tbl[2] = '{period: 8,  dir: 1'b0, use_jog: 1'b0, decoy_en: 1'b0, nsteps: 2, exp_spacing: 8};
        tbl[3] = '{period: 9,  dir: 1'b0, use_jog: 1'b1, decoy_en: 1'b1, nsteps: 2, exp_spacing: 9};
        tbl[4] = '{period: 1,  dir: 1'b1, use_jog: 1'b1, decoy_en: 1'b0, nsteps: 2, exp_spacing: 8};

        // Reset state.
        at_cycle(2);
        check("rst_step", drv_step, 1'b0);
        check("rst_enable", drv_enable, 1'b0);
        check("rst_dir", drv_dir, 1'b0);
        check("rst_owner", owner, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", step_strobe, 1'b0);
        check("rst_position", position, '0);
        drive_at(3);
        rst = 1'b0;

        // Table-driven single-requester runs.
        for (int i = 0; i < 5; i++) begin
            run_track($sformatf("tbl%0d", i), tbl[i].period, tbl[i].dir, tbl[i].use_jog,
                      tbl[i].decoy_en, tbl[i].nsteps, tbl[i].exp_spacing);
        end

        // Randomized runs against the period-clamp model.
        for (int i = 0; i < 6; i++) begin
            period = $urandom_range(1, 30);
            dir    = 1'($urandom_range(0, 1));
            sp     = (period < MIN_PERIOD) ? MIN_PERIOD : period;
            run_track($sformatf("rand%0d", i), period, dir, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(1, 4), sp);
        end

        // Jog preempts tracking mid-step.
        t0 = cyc + 2; first = t0 + FIRST_OFS;
        drive_at(t0);
        trk_en = 1'b1; trk_period = 20; trk_dir = 1'b1;
        at_cycle(first);
        check("pre_trk_pos", position, pos_model + 1);
        drive_at(first + 1);
        jog_en = 1'b1; jog_period = 12; jog_dir = 1'b0;
        at_cycle(first + 1);
        check("pre_owner_mid", owner, 2'd1);
        check("pre_step_mid", drv_step, 1'b1);
        at_cycle(first + 19);
        check("pre_owner_low", owner, 2'd1);
        at_cycle(first + 20);
        check("pre_owner_jog", owner, 2'd2);
        check("pre_dir_wait", drv_dir, 1'b1);
        at_cycle(first + 22);
        check("pre_dir_hold_end", drv_dir, 1'b1);
        at_cycle(first + 23);
        check("pre_dir_fall", drv_dir, 1'b0);
        at_cycle(first + 25);
        check("pre_step_setup", drv_step, 1'b0);
        at_cycle(first + 26);
        check("pre_jog_rise", step_strobe, 1'b1);
        check("pre_jog_pos", position, pos_model);
        at_cycle(first + 38);
        check("pre_jog_rise2", step_strobe, 1'b1);
        check("pre_jog_pos2", position, pos_model - 1);
        drive_at(first + 40);
        idle_inputs();
        at_cycle(first + 59);
        check("pre_en_hold", drv_enable, 1'b1);
        at_cycle(first + 60);
        check("pre_en_release", drv_enable, 1'b0);
        pos_model = pos_model - 1;

        // Re-request during HOLD skips WAKE, dir change needs no DIR_WAIT.
        t0 = cyc + 2; first = t0 + FIRST_OFS;
        drive_at(t0);
        rises.delete();
        trk_en = 1'b1; trk_period = 10; trk_dir = 1'b1;
        drive_at(first + 3);
        trk_en = 1'b0;
        at_cycle(first + 12);
        check("hold_enable", drv_enable, 1'b1);
        check("hold_step", drv_step, 1'b0);
        drive_at(first + 15);
        trk_en = 1'b1; trk_dir = 1'b0;
        at_cycle(first + 15);
        check("hold_dir_old", drv_dir, 1'b1);
        at_cycle(first + 16);
        check("hold_dir_new", drv_dir, 1'b0);
        at_cycle(first + 18);
        check("hold_step_pre", drv_step, 1'b0);
        at_cycle(first + 19);
        check("hold_step_rise", drv_step, 1'b1);
        check("hold_pos", position, pos_model);
        drive_at(first + 22);
        idle_inputs();
        at_cycle(first + 38);
        check("hold_en_hold", drv_enable, 1'b1);
        at_cycle(first + 39);
        check("hold_en_release", drv_enable, 1'b0);
        check("hold_nrises", rises.size(), 2);
        if (rises.size() == 2) check("hold_rise_gap", rises[1] - rises[0], 19);

        // Emergency stop inside STEP_HIGH, then a full WAKE after release.
        t0 = cyc + 2; first = t0 + FIRST_OFS;
        drive_at(t0);
        trk_en = 1'b1; trk_period = 8; trk_dir = 1'b1;
        drive_at(first);
        estop = 1'b1;
        at_cycle(first);
        check("estop_step_before", drv_step, 1'b1);
        at_cycle(first + 1);
        check("estop_step", drv_step, 1'b0);
        check("estop_enable", drv_enable, 1'b0);
        check("estop_owner", owner, 2'd0);
        check("estop_pos", position, pos_model + 1);
        drive_at(first + 3);
        estop = 1'b0;
        at_cycle(first + 3);
        check("estop_held_idle", drv_enable, 1'b0);
        at_cycle(first + 4);
        check("estop_rewake", drv_enable, 1'b1);
        at_cycle(first + 11);
        check("estop_no_early_step", drv_step, 1'b0);
        at_cycle(first + 12);
        check("estop_step_after", drv_step, 1'b1);
        check("estop_pos_after", position, pos_model + 2);
        drive_at(first + 15);
        idle_inputs();
        at_cycle(first + 30);
        check("estop_en_release", drv_enable, 1'b0);
        pos_model = pos_model + 2;

        // Clear coincident with a reverse step, then wrap back to zero.
        t0 = cyc + 2; first = t0 + FIRST_OFS;
        drive_at(t0);
        trk_en = 1'b1; trk_period = 8; trk_dir = 1'b0;
        drive_at(first - 1);
        pos_clr = 1'b1;
        drive_at(first);
        pos_clr = 1'b0;
        at_cycle(first);
        check("clr_step_pos", position, {POS_W{1'b1}});
        drive_at(first + 1);
        trk_dir = 1'b1;
        at_cycle(first + 10);
        check("clr_dir_wait", drv_dir, 1'b0);
        at_cycle(first + 11);
        check("clr_dir_new", drv_dir, 1'b1);
        at_cycle(first + 14);
        check("wrap_step", drv_step, 1'b1);
        check("wrap_pos", position, '0);
        at_cycle(first + 22);
        check("wrap_pos_next", position, POS_W'(1));
        drive_at(first + 24);
        pos_clr = 1'b1;
        drive_at(first + 25);
        pos_clr = 1'b0;
        at_cycle(first + 25);
        check("clr_alone", position, '0);
        drive_at(first + 26);
        idle_inputs();
        at_cycle(first + 39);
        check("clr_en_hold", drv_enable, 1'b1);
        at_cycle(first + 40);
        check("clr_en_release", drv_enable, 1'b0);
        pos_model = '0;

        // Asynchronous reset in the middle of a step.
        t0 = cyc + 2; first = t0 + FIRST_OFS;
        drive_at(t0);
        trk_en = 1'b1; trk_period = 8; trk_dir = 1'b1;
        at_cycle(first);
        check("arst_step_before", drv_step, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_step", drv_step, 1'b0);
        check("arst_enable", drv_enable, 1'b0);
        check("arst_owner", owner, 2'd0);
        check("arst_strobe", step_strobe, 1'b0);
        check("arst_position", position, '0);
        idle_inputs();
        drive_at(cyc + 2);
        rst = 1'b0;
        at_cycle(cyc + 2);
        check("arst_stays_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
